packet_history_strip: RTL and testbench

//  Receive-side peer of the history inserter. Every input packet carries 4 prepended 512b history beats:
//  16 x 112b tuples plus a 4b write pointer. Block strips these beats, forwards the original packet

---
 rtl/packet_history_pkg.sv | 39 +++
 rtl/axis_reg_slice.sv | 44 ++++
 rtl/packet_history_strip.sv | 161 ++++++++++++++++
 tb/tb_packet_history_strip.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_history_pkg.sv
// Shared constants and types for the history inserter/stripper pair:
// header geometry, pointer location, tuple slot and field offsets, FSM encoding.
package packet_history_pkg;

   localparam int TUPLE_WIDTH     = 112;
   localparam int NUM_HISTORY     = 16;
   localparam int HDR_BEATS       = 4;
   localparam int TUPLES_PER_BEAT = NUM_HISTORY / HDR_BEATS;
   localparam int PTR_WIDTH       = 4;
   localparam int PTR_LSB         = 60;
   localparam int HDR_DATA_WIDTH  = 512;
   localparam int HIST_WIDTH      = TUPLE_WIDTH * NUM_HISTORY;

   // Field positions inside one 112b tuple
   localparam int SRC_IP_MSB  = 111;
   localparam int DST_IP_MSB  = 79;
   localparam int SRC_L4_MSB  = 47;
   localparam int DST_L4_MSB  = 31;
   localparam int PKT_LEN_MSB = 15;

   localparam logic [PTR_WIDTH-1:0] PTR_ONE = 1;

   typedef enum logic [2:0] {
      ST_HDR0 = 3'd0,
      ST_HDR1 = 3'd1,
      ST_HDR2 = 3'd2,
      ST_HDR3 = 3'd3,
      ST_PASS = 3'd4
   } strip_state_t;

   function automatic int slot_msb(input int slot);
      return HDR_DATA_WIDTH - 1 - TUPLE_WIDTH * slot;
   endfunction

   function automatic int tuple_msb(input int idx);
      return HIST_WIDTH - 1 - TUPLE_WIDTH * idx;
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-register AXI-Stream pipeline stage: one cycle latency, full throughput,
// holds its beat while the downstream stalls.
module axis_reg_slice #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = 64,
   parameter int USER_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic [KEEP_WIDTH-1:0] s_tkeep,
   input  logic [USER_WIDTH-1:0] s_tuser,
   input  logic                  s_tlast,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic [KEEP_WIDTH-1:0] m_tkeep,
   output logic [USER_WIDTH-1:0] m_tuser,
   output logic                  m_tlast,
   output logic                  m_tvalid,
   input  logic                  m_tready
);

   assign s_tready = !m_tvalid || m_tready;

   always_ff @(posedge clk) begin
      if (reset) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tkeep  <= '0;
         m_tuser  <= '0;
         m_tlast  <= 1'b0;
      end else if (s_tready) begin
         m_tvalid <= s_tvalid;
         if (s_tvalid) begin
            m_tdata <= s_tdata;
            m_tkeep <= s_tkeep;
            m_tuser <= s_tuser;
            m_tlast <= s_tlast;
         end
      end
   end

endmodule

// File: rtl/packet_history_strip.sv
// Strips the four prepended history beats from every packet, forwards the payload
// unchanged through a register slice and publishes the recovered history record.
module packet_history_strip
   import packet_history_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH  = 512,
   parameter int C_AXIS_TUSER_WIDTH = 128
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   output logic                            hist_valid,
   output logic [PTR_WIDTH-1:0]            hist_ptr,
   output logic [HIST_WIDTH-1:0]           hist_tuples,
   output logic [15:0]                     seq_err_cnt,
   output logic [15:0]                     runt_cnt,
   output logic [31:0]                     pkt_cnt
);

   strip_state_t state, state_next;

   logic                  s_hs;
   logic                  in_hdr;
   logic [1:0]            hdr_beat;
   logic                  hdr_accept;
   logic                  runt_drop;
   logic                  pass_last;
   logic                  publish;
   logic                  slice_s_valid;
   logic                  slice_s_ready;
   logic [PTR_WIDTH-1:0]  shadow_ptr;
   logic [PTR_WIDTH-1:0]  expected_ptr;
   logic                  have_prev;
   logic [HIST_WIDTH-1:0] shadow_tuples;
   logic [HIST_WIDTH-1:0] shadow_next;

   assign s_hs         = s_axis_tvalid && s_axis_tready;
   assign in_hdr       = (state != ST_PASS);
   assign hdr_beat     = state[1:0];
   assign hdr_accept   = s_hs && in_hdr;
   assign runt_drop    = hdr_accept && s_axis_tlast;
   assign pass_last    = s_hs && !in_hdr && s_axis_tlast;
   assign publish      = hdr_accept && (state == ST_HDR3) && !s_axis_tlast;
   assign expected_ptr = hist_ptr + PTR_ONE;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_HDR0;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (s_hs) begin
         if (s_axis_tlast) begin
            state_next = ST_HDR0;
         end else begin
            case (state)
               ST_HDR0: state_next = ST_HDR1;
               ST_HDR1: state_next = ST_HDR2;
               ST_HDR2: state_next = ST_HDR3;
               ST_HDR3: state_next = ST_PASS;
               ST_PASS: state_next = ST_PASS;
               default: state_next = ST_HDR0;
            endcase
         end
      end
   end

   // Header beats are always accepted; payload follows the output stage's readiness.
   always_comb begin
      s_axis_tready = 1'b1;
      slice_s_valid = 1'b0;
      if (state == ST_PASS) begin
         s_axis_tready = slice_s_ready;
         slice_s_valid = s_axis_tvalid;
      end
   end

   always_comb begin
      shadow_next = shadow_tuples;
      for (int b = 0; b < HDR_BEATS; b++) begin
         if (hdr_accept && hdr_beat == 2'(b)) begin
            for (int j = 0; j < TUPLES_PER_BEAT; j++) begin
               shadow_next[tuple_msb(b*TUPLES_PER_BEAT + j) -: TUPLE_WIDTH] =
                  s_axis_tdata[slot_msb(j) -: TUPLE_WIDTH];
            end
         end
      end
   end

   // The shadow collects a record in flight so a runt never disturbs the published one.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_tuples <= '0;
         shadow_ptr    <= '0;
         hist_valid    <= 1'b0;
         hist_ptr      <= '0;
         hist_tuples   <= '0;
         have_prev     <= 1'b0;
      end else begin
         hist_valid <= 1'b0;
         if (hdr_accept) shadow_tuples <= shadow_next;
         if (hdr_accept && state == ST_HDR0)
            shadow_ptr <= s_axis_tdata[PTR_LSB +: PTR_WIDTH];
         if (publish) begin
            hist_valid  <= 1'b1;
            hist_ptr    <= shadow_ptr;
            hist_tuples <= shadow_next;
            have_prev   <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seq_err_cnt <= '0;
         runt_cnt    <= '0;
         pkt_cnt     <= '0;
      end else begin
         if (publish && have_prev && shadow_ptr != expected_ptr && seq_err_cnt != '1)
            seq_err_cnt <= seq_err_cnt + 16'd1;
         if (runt_drop && runt_cnt != '1)
            runt_cnt <= runt_cnt + 16'd1;
         if (pass_last)
            pkt_cnt <= pkt_cnt + 32'd1;
      end
   end

   axis_reg_slice #(
      .DATA_WIDTH (C_AXIS_DATA_WIDTH),
      .KEEP_WIDTH (C_AXIS_DATA_WIDTH/8),
      .USER_WIDTH (C_AXIS_TUSER_WIDTH)
   ) u_out_slice (
      .clk      (clk),
      .reset    (reset),
      .s_tdata  (s_axis_tdata),
      .s_tkeep  (s_axis_tkeep),
      .s_tuser  (s_axis_tuser),
      .s_tlast  (s_axis_tlast),
      .s_tvalid (slice_s_valid),
      .s_tready (slice_s_ready),
      .m_tdata  (m_axis_tdata),
      .m_tkeep  (m_axis_tkeep),
      .m_tuser  (m_axis_tuser),
      .m_tlast  (m_axis_tlast),
      .m_tvalid (m_axis_tvalid),
      .m_tready (m_axis_tready)
   );

endmodule

// File: tb/tb_packet_history_strip.sv
// Directed bench for packet_history_strip: a per-packet vector table plus
// hand-written backpressure, back-to-back and mid-packet reset sequences.
module tb_packet_history_strip;

   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  keep;
      logic [127:0] user;
      logic         last;
   } beat_t;

   typedef struct packed {
      logic [3:0]    ptr;
      logic [1791:0] tuples;
   } hist_rec_t;

   typedef struct {
      int ptr;
      int base;
      int beats;
      int runt_beat;
      int exp_seq;
      int exp_runt;
      int exp_pkt;
      int exp_hist_ptr;
   } vector_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [511:0]  s_axis_tdata = '0;
   logic [63:0]   s_axis_tkeep = '0;
   logic [127:0]  s_axis_tuser = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic [511:0]  m_axis_tdata;
   logic [63:0]   m_axis_tkeep;
   logic [127:0]  m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic          hist_valid;
   logic [3:0]    hist_ptr;
   logic [1791:0] hist_tuples;
   logic [15:0]   seq_err_cnt;
   logic [15:0]   runt_cnt;
   logic [31:0]   pkt_cnt;

   int errors = 0;
   int checks = 0;
   int hdr_stall = 0;
   int pay_stall = 0;
   logic bp_mode = 1'b0;

   beat_t     exp_q[$];
   beat_t     got_q[$];
   hist_rec_t hist_exp_q[$];
   hist_rec_t hist_got_q[$];
   vector_t   tbl[8];

   packet_history_strip dut (
      .clk           (clk),
      .reset         (reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .hist_valid    (hist_valid),
      .hist_ptr      (hist_ptr),
      .hist_tuples   (hist_tuples),
      .seq_err_cnt   (seq_err_cnt),
      .runt_cnt      (runt_cnt),
      .pkt_cnt       (pkt_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(negedge clk);
         if (bp_mode) m_axis_tready = ~m_axis_tready;
         else         m_axis_tready = 1'b1;
      end
   end

   // Records every output handshake and history pulse just ahead of the edge that completes it.
   always @(negedge clk) begin
      #2;
      if (m_axis_tvalid && m_axis_tready)
         got_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast});
      if (hist_valid)
         hist_got_q.push_back({hist_ptr, hist_tuples});
   end

   function automatic logic [511:0] make_hdr(input int b, input int ptr, input int base);
      logic [511:0] d;
      d = '0;
      d[63:0] = 64'hDEAD_BEEF_CAFE_F00D;
      for (int j = 0; j < 4; j++) d[511-112*j -: 112] = 112'(base + 4*b + j);
      if (b == 0) d[63:60] = 4'(ptr);
      return d;
   endfunction

   function automatic logic [1791:0] make_hist(input int base);
      logic [1791:0] h;
      h = '0;
      for (int i = 0; i < 16; i++) h[1791-112*i -: 112] = 112'(base + i);
      return h;
   endfunction

   function automatic beat_t make_payload(input int base, input int k, input int n);
      beat_t bt;
      for (int w = 0; w < 16; w++) bt.data[32*w +: 32] = 32'(base * 4096 + k * 16 + w);
      bt.last = (k == n - 1);
      bt.keep = bt.last ? 64'h00FF_FFFF_FFFF_FFFF : '1;
      bt.user = {96'h0, 32'(base + k)};
      return bt;
   endfunction

   task automatic send_beat(input beat_t bt, input bit is_hdr);
      int  waited;
      logic hs;
      waited = 0;
      @(negedge clk);
      s_axis_tdata  = bt.data;
      s_axis_tkeep  = bt.keep;
      s_axis_tuser  = bt.user;
      s_axis_tlast  = bt.last;
      s_axis_tvalid = 1'b1;
      forever begin
         #1;
         hs = s_axis_tready;
         @(posedge clk);
         if (hs) break;
         waited++;
         if (is_hdr) hdr_stall++;
         else        pay_stall++;
         if (waited > 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: got no s_axis_tready, required within 200 cycles");
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic apply_stimulus(input int ptr, input int base, input int n, input int runt_beat);
      beat_t bt;
      for (int b = 0; b < 4; b++) begin
         bt.data = make_hdr(b, ptr, base);
         bt.keep = 64'h0F0F_0F0F_0F0F_0F0F;
         bt.user = 128'hBAD0_BAD0;
         bt.last = (runt_beat == b);
         send_beat(bt, 1'b1);
         if (bt.last) return;
      end
      hist_exp_q.push_back({4'(ptr), make_hist(base)});
      for (int k = 0; k < n; k++) begin
         bt = make_payload(base, k, n);
         exp_q.push_back(bt);
         send_beat(bt, 1'b0);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
      end
   endtask

   task automatic compare_stream(input string name);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("[TB] FAIL %s beat_count: got %0d required %0d", name, got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("[TB] FAIL %s beat%0d: got data 0x%0h keep 0x%0h last %0b required data 0x%0h keep 0x%0h last %0b",
                        name, i, got_q[i].data[63:0], got_q[i].keep, got_q[i].last,
                        exp_q[i].data[63:0], exp_q[i].keep, exp_q[i].last);
            end
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic compare_hist(input string name);
      checks++;
      if (hist_got_q.size() != hist_exp_q.size()) begin
         errors++;
         $display("[TB] FAIL %s hist_pulses: got %0d required %0d", name, hist_got_q.size(), hist_exp_q.size());
      end else begin
         foreach (hist_exp_q[i]) begin
            checks++;
            if (hist_got_q[i] !== hist_exp_q[i]) begin
               errors++;
               $display("[TB] FAIL %s hist%0d: got ptr %0d tuple5 0x%0h required ptr %0d tuple5 0x%0h",
                        name, i, hist_got_q[i].ptr, hist_got_q[i].tuples[1791-560 -: 112],
                        hist_exp_q[i].ptr, hist_exp_q[i].tuples[1791-560 -: 112]);
            end
         end
      end
      hist_got_q.delete();
      hist_exp_q.delete();
   endtask

   task automatic check_counters(input string name, input int seq, input int runt, input int pkt);
      check_output({name, "_seq_err_cnt"}, 64'(seq_err_cnt), 64'(seq));
      check_output({name, "_runt_cnt"},    64'(runt_cnt),    64'(runt));
      check_output({name, "_pkt_cnt"},     64'(pkt_cnt),     64'(pkt));
   endtask

   initial begin
      //          ptr  base    beats runt seq runt pkt hptr
      tbl[0] = '{3,   'h100,  2,    -1,  0,  0,   1,  3};
      tbl[1] = '{4,   'h200,  3,    -1,  0,  0,   2,  4};
      tbl[2] = '{5,   'h300,  1,    -1,  0,  0,   3,  5};
      tbl[3] = '{7,   'h400,  2,    -1,  1,  0,   4,  7};
      tbl[4] = '{15,  'h500,  1,    -1,  2,  0,   5,  15};
      tbl[5] = '{0,   'h600,  2,    -1,  2,  0,   6,  0};
      tbl[6] = '{1,   'h700,  2,    2,   2,  1,   6,  0};
      tbl[7] = '{1,   'h800,  2,    -1,  2,  1,   7,  1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_output("reset_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check_output("reset_hist_valid", 64'(hist_valid), 64'd0);
      check_output("reset_hist_ptr", 64'(hist_ptr), 64'd0);
      check_output("reset_hist_tuples_zero", 64'(hist_tuples == '0), 64'd1);
      check_output("reset_s_tready", 64'(s_axis_tready), 64'd1);
      check_counters("reset", 0, 0, 0);
      reset = 1'b0;

      for (int r = 0; r < 8; r++) begin
         apply_stimulus(tbl[r].ptr, tbl[r].base, tbl[r].beats, tbl[r].runt_beat);
         idle(6);
         check_counters($sformatf("vec%0d", r), tbl[r].exp_seq, tbl[r].exp_runt, tbl[r].exp_pkt);
         check_output($sformatf("vec%0d_hist_ptr", r), 64'(hist_ptr), 64'(tbl[r].exp_hist_ptr));
         compare_stream($sformatf("vec%0d", r));
         compare_hist($sformatf("vec%0d", r));
      end

      // Downstream stalls every other cycle during a 6-beat payload.
      hdr_stall = 0;
      bp_mode = 1'b1;
      apply_stimulus(2, 'h900, 6, -1);
      idle(1);
      bp_mode = 1'b0;
      idle(8);
      check_output("bp_hdr_stall", 64'(hdr_stall), 64'd0);
      check_counters("bp", 2, 1, 8);
      compare_stream("bp");
      compare_hist("bp");

      // Three packets with no idle gap; payload must never stall.
      hdr_stall = 0;
      pay_stall = 0;
      apply_stimulus(3, 'hA00, 3, -1);
      apply_stimulus(4, 'hB00, 3, -1);
      apply_stimulus(5, 'hC00, 3, -1);
      idle(6);
      check_output("b2b_pay_stall", 64'(pay_stall), 64'd0);
      check_output("b2b_hdr_stall", 64'(hdr_stall), 64'd0);
      check_counters("b2b", 2, 1, 11);
      compare_stream("b2b");
      compare_hist("b2b");

      // Reset lands while payload beat 2 of 4 is offered.
      begin
         beat_t bt;
         for (int b = 0; b < 4; b++) begin
            bt.data = make_hdr(b, 6, 'hD00);
            bt.keep = '1;
            bt.user = '0;
            bt.last = 1'b0;
            send_beat(bt, 1'b1);
         end
         send_beat(make_payload('hD00, 0, 4), 1'b0);
         @(negedge clk);
         bt = make_payload('hD00, 1, 4);
         s_axis_tdata  = bt.data;
         s_axis_tkeep  = bt.keep;
         s_axis_tuser  = bt.user;
         s_axis_tlast  = bt.last;
         s_axis_tvalid = 1'b1;
         reset = 1'b1;
         @(negedge clk);
         #1;
         check_output("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
         check_output("rst_hist_valid", 64'(hist_valid), 64'd0);
         check_output("rst_hist_ptr", 64'(hist_ptr), 64'd0);
         check_counters("rst", 0, 0, 0);
         reset = 1'b0;
         s_axis_tvalid = 1'b0;
         #3;
         got_q.delete();
         exp_q.delete();
         hist_got_q.delete();
         hist_exp_q.delete();
      end
      apply_stimulus(9, 'hE00, 2, -1);
      idle(6);
      check_counters("post_rst", 0, 0, 1);
      check_output("post_rst_hist_ptr", 64'(hist_ptr), 64'd9);
      compare_stream("post_rst");
      compare_hist("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no completion, required finish before 200000 time units");
      $fatal(1, "[TB] timeout");
   end

endmodule
